uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single UART byte transmitter between NUM_REQ independent requesters. Examples: command responder, debug logger, status reporter.
- Requesters offer bytes over a valid/ready handshake.
- Round-robin arbitration with packet lock: once a requester wins, it keeps the transmitter until it sends a byte flagged last.
- Sequences the transmitter's level-style start/busy interface and detects a transmitter that never acknowledges a start.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ACK_TIMEOUT, 16, clk cycles allowed between tx_start and tx_busy rising before the byte is abandoned (≥2).

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- req_valid  input  NUM_REQ  requester i offers a byte
- req_data  input  8*NUM_REQ  byte of requester i in bits [8i+7:8i]
- req_last  input  NUM_REQ  byte of requester i ends its packet
- req_ready  output  NUM_REQ  one-hot; byte accepted when valid&ready in same cycle
- tx_data  output  8  registered byte to transmitter trans_data
- tx_start  output  1  one-cycle start pulse to transmitter tran_start
- tx_busy  input  1  transmitter busy (high while frame in flight)
- grant_id  output  $clog2(NUM_REQ)  current/most recent owner
- locked  output  1  packet lock held
- err_timeout  output  1  one-cycle pulse: transmitter failed to go busy

Behaviour:
- Reset values:
  - Outputs: req_ready=0, tx_data=0, tx_start=0, grant_id=0, locked=0, err_timeout=0.
  - Internal: state=IDLE, rr pointer=0, timeout counter=0.
- States are IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE.
- IDLE:
  - Candidate set: if locked, only grant_id; else all requesters.
  - Winner: first valid candidate scanning from (grant_id+1) mod NUM_REQ upward with wrap. The pointer starts effectively at 0 after reset: the scan begins at 1, so 0 is last priority on the first arbitration.
  - If a winner exists and tx_busy=0: req_ready[winner]=1 combinationally in that cycle only.
  - On the same edge: tx_data<=req_data[winner], grant_id<=winner, last flag captured, go LAUNCH.
  - If tx_busy=1 (transmitter still in a frame from elsewhere), no acceptance.
- LAUNCH: tx_start=1 for exactly this cycle; timeout counter cleared; go WAIT_BUSY.
- WAIT_BUSY:
  - If tx_busy=1, go WAIT_DONE.
  - Otherwise increment the counter. When it reaches ACK_TIMEOUT-1 with tx_busy still 0: err_timeout=1 for one cycle, byte dropped, lock released, go IDLE.
- WAIT_DONE: when tx_busy=0, go IDLE.
  - If the captured last=1, locked<=0.
  - Else locked<=1 (owner retained).
- Latency: acceptance edge → tx_start high 1 cycle later. Minimum IDLE-to-IDLE is 3 cycles plus the frame duration.
- Only one req_ready ever high; never high outside IDLE.
- tx_data is stable from acceptance until return to IDLE.
- While locked, the owner dropping req_valid stalls the arbiter indefinitely; other requesters are not served. This is intentional packet atomicity.
- A single-byte packet (last=1 on first byte) never sets locked.
- req_data/req_last of non-granted requesters are ignored.
- Reset mid-frame returns to IDLE immediately and releases the lock.
- The transmitter, reset by the same rst, also returns idle; no byte is replayed.

Decomposition:
- Shared package uart_pkg holds:
  - State encoding localparams: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
  - Default ACK_TIMEOUT.
  - The $clog2-based ID width function.
- One natural sub-module: rr_select (combinational round-robin priority picker).
  - Inputs: candidate mask and start index.
  - Outputs: winner index and found flag.
  - Reusable for future RX/command arbiters.

Test Plan:
- Single requester: req_valid=0001, data 0x55, last=1 → req_ready=0001 one cycle; tx_start pulse next cycle; frame 0x55 on line; locked stays 0; back to IDLE after tx_busy falls.
- Round-robin: all four valid, each last=1, data 0xA0..0xA3 → grant order 1,2,3,0 (first pass from reset); each gets exactly one byte per rotation.
- Packet lock: requester 2 sends 0x10,0x11,0x12 (last on 0x12) while requester 0 valid throughout → three bytes from 2 contiguous; requester 0 served only after 0x12 completes; locked high between bytes.
- Timeout: tie tx_busy=0 → after LAUNCH, err_timeout pulses exactly ACK_TIMEOUT cycles later (16); state IDLE; lock released; next requester served.
- Reset mid-packet: assert rst in WAIT_DONE of locked packet → all outputs to reset values same cycle; after release the arbiter starts fresh and no byte is repeated.
- Busy gate: hold tx_busy=1 externally in IDLE with req_valid=0001 → req_ready stays 0 until tx_busy falls, then accepts on the following cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encoding, default ack timeout and ID width helper
// for the UART transmit arbiter and its round-robin picker.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

  localparam int ACK_TIMEOUT_DEF = 16;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_select.sv
// rr_select: combinational round-robin picker; first set bit of mask
// scanning upward from start with wrap. Ports: mask, start -> idx, found.
module rr_select
  import uart_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = id_w(N)
) (
  input  logic [N-1:0] mask,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         found
);

  // Upper segment [start..N-1] first, then the wrapped [0..start-1].
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && mask[i] && i >= int'(start)) begin
        idx   = W'(i);
        found = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && mask[i] && i < int'(start)) begin
        idx   = W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART byte transmitter among NUM_REQ
// valid/ready requesters with round-robin and packet lock.
// Ports: req_valid/req_data/req_last/req_ready (requesters),
// tx_data/tx_start/tx_busy (transmitter), grant_id/locked/err_timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ     = 4,
  parameter  int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
  localparam int IW          = id_w(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic [IW-1:0]        grant_id,
  output logic                 locked,
  output logic                 err_timeout
);

  localparam int CW = id_w(ACK_TIMEOUT);

  arb_state_t         state_q;
  arb_state_t         state_d;
  logic [CW-1:0]      cnt_q;
  logic               last_q;
  logic [NUM_REQ-1:0] own;
  logic [NUM_REQ-1:0] cand;
  logic [IW-1:0]      start;
  logic [IW-1:0]      win;
  logic               found;
  logic               accept;
  logic               done;
  logic [7:0]         sel_data;
  logic               sel_last;

  // While locked only the owner may win; scan starts after the owner.
  always_comb begin
    own           = '0;
    own[grant_id] = 1'b1;
    cand          = (locked ? own : '1) & req_valid;
    start         = (grant_id == IW'(NUM_REQ-1)) ? '0
                                                 : grant_id + 1'b1;
  end

  rr_select #(
    .N(NUM_REQ)
  ) u_rr (
    .mask (cand),
    .start(start),
    .idx  (win),
    .found(found)
  );

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == IW'(i)) begin
        sel_data = req_data[8*i +: 8];
        sel_last = req_last[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    req_ready   = '0;
    tx_start    = 1'b0;
    err_timeout = 1'b0;
    accept      = 1'b0;
    done        = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (found && !tx_busy) begin
          accept         = 1'b1;
          req_ready[win] = 1'b1;
          state_d        = LAUNCH;
        end
      end
      (state_q == LAUNCH): begin
        tx_start = 1'b1;
        state_d  = WAIT_BUSY;
      end
      (state_q == WAIT_BUSY): begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CW'(ACK_TIMEOUT-1)) begin
          err_timeout = 1'b1;
          state_d     = IDLE;
        end
      end
      (state_q == WAIT_DONE): begin
        if (!tx_busy) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b0;
      tx_data  <= '0;
      grant_id <= '0;
      locked   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        tx_data  <= sel_data;
        grant_id <= win;
        last_q   <= sel_last;
      end
      if (tx_start) begin
        cnt_q <= '0;
      end else if (state_q == WAIT_BUSY && !tx_busy) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (err_timeout) begin
        locked <= 1'b0;
      end else if (done) begin
        locked <= !last_q;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed phases plus random traffic checked
// against a transaction-level arbitration and transmitter model.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int AT = 16;

  logic            clk       = 1'b0;
  logic            rst       = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [8*NR-1:0] req_data  = '0;
  logic [NR-1:0]   req_last  = '0;
  logic [NR-1:0]   req_ready;
  logic [7:0]      tx_data;
  logic            tx_start;
  logic            tx_busy   = 1'b0;
  logic [1:0]      grant_id;
  logic            locked;
  logic            err_timeout;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ    (NR),
    .ACK_TIMEOUT(AT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .grant_id   (grant_id),
    .locked     (locked),
    .err_timeout(err_timeout)
  );

  int checks   = 0;
  int failures = 0;

  // per-requester byte queues, entries {last, data}
  logic [8:0] rq [NR][$];
  int         order_q[$];

  int         m_gid    = 0;
  bit         m_locked = 1'b0;
  bit         pend     = 1'b0;
  bit         cur_last = 1'b0;
  logic [7:0] cur_byte = '0;
  bit         got_busy = 1'b0;
  int         since    = 0;

  int busy_left  = 0;
  bit force_busy = 1'b0;
  int drop_idx   = -1;
  int start_no   = 0;
  bit rnd_drop   = 1'b0;
  int frame_min  = 2;
  int frame_max  = 4;
  int n_err      = 0;

  bit p_acc   = 1'b0;
  bit p_rel   = 1'b0;
  bit p_err   = 1'b0;
  bit p_start = 1'b0;
  int p_w     = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic int winner(input logic [NR-1:0] v);
    if (m_locked) return v[m_gid] ? m_gid : -1;
    for (int k = 1; k <= NR; k++)
      if (v[(m_gid + k) % NR]) return (m_gid + k) % NR;
    return -1;
  endfunction

  function automatic int qtotal();
    int s = 0;
    for (int i = 0; i < NR; i++) s += rq[i].size();
    return s;
  endfunction

  task automatic push_pkt(input int r, input int len);
    for (int k = 0; k < len; k++)
      rq[r].push_back({k == len - 1, 8'($urandom)});
  endtask

  task automatic cyc();
    bit            exp_start;
    bit            exp_err;
    bit            exp_rel;
    logic [NR-1:0] exp_ready;
    int            w;
    @(posedge clk);
    if (busy_left > 0) busy_left--;
    if (p_start) begin
      if (start_no != drop_idx &&
          !(rnd_drop && $urandom_range(15) == 0))
        busy_left = $urandom_range(frame_max, frame_min);
      start_no++;
    end
    if (p_rel) begin
      pend     = 1'b0;
      m_locked = !cur_last;
    end
    if (p_err) begin
      pend     = 1'b0;
      m_locked = 1'b0;
    end
    exp_start = 1'b0;
    if (p_acc) begin
      {cur_last, cur_byte} = rq[p_w].pop_front();
      pend     = 1'b1;
      got_busy = 1'b0;
      since    = 0;
      m_gid    = p_w;
      order_q.push_back(p_w);
      exp_start = 1'b1;
    end
    #1;
    tx_busy = force_busy || busy_left > 0;
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = rq[i].size() > 0;
      if (req_valid[i]) begin
        {req_last[i], req_data[8*i +: 8]} = rq[i][0];
      end else begin
        req_last[i]        = 1'($urandom);
        req_data[8*i +: 8] = 8'($urandom);
      end
    end
    #1;
    if (pend && !exp_start && !got_busy) since++;
    if (pend && !exp_start && tx_busy) got_busy = 1'b1;
    exp_err = pend && !got_busy && since == AT && !tx_busy;
    exp_rel = pend && got_busy && !tx_busy;
    w = winner(req_valid);
    exp_ready = '0;
    if (!pend && !tx_busy && w >= 0) exp_ready[w] = 1'b1;
    chk("req_ready", req_ready, exp_ready);
    chk("tx_start", tx_start, exp_start);
    chk("err_timeout", err_timeout, exp_err);
    chk("locked", locked, m_locked);
    chk("grant_id", grant_id, m_gid);
    if (pend) chk("tx_data", tx_data, cur_byte);
    if (err_timeout === 1'b1) n_err++;
    p_acc   = exp_ready != 0;
    p_w     = w;
    p_rel   = exp_rel;
    p_err   = exp_err;
    p_start = tx_start === 1'b1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((pend || p_acc || qtotal() > 0) && n < budget) begin
      cyc();
      n++;
    end
    chk("drain_bound", n < budget, 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst        = 1'b1;
    tx_busy    = 1'b0;
    req_valid  = '0;
    force_busy = 1'b0;
    busy_left  = 0;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err_timeout", err_timeout, 0);
    for (int i = 0; i < NR; i++) rq[i].delete();
    order_q.delete();
    m_gid    = 0;
    m_locked = 1'b0;
    pend     = 1'b0;
    p_acc    = 1'b0;
    p_rel    = 1'b0;
    p_err    = 1'b0;
    p_start  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk_order(input string tag, input int e0, input int e1,
                           input int e2, input int e3, input int n);
    int e[4];
    e = '{e0, e1, e2, e3};
    chk({tag, "_len"}, order_q.size(), n);
    for (int k = 0; k < n && k < order_q.size(); k++)
      chk(tag, order_q[k], e[k]);
    order_q.delete();
  endtask

  initial begin
    int n;
    do_reset();

    // single requester, single-byte packet
    rq[0].push_back({1'b1, 8'h55});
    drain(200);
    chk_order("single_order", 0, 0, 0, 0, 1);

    // round-robin from grant_id 0: 1,2,3,0
    for (int i = 0; i < NR; i++) rq[i].push_back({1'b1, 8'(8'hA0 + i)});
    drain(400);
    chk_order("rr_order", 1, 2, 3, 0, 4);

    // packet lock: req2 three bytes contiguous, then req0
    rq[2].push_back({1'b0, 8'h10});
    rq[2].push_back({1'b0, 8'h11});
    rq[2].push_back({1'b1, 8'h12});
    rq[0].push_back({1'b1, 8'h77});
    drain(400);
    chk_order("lock_order", 2, 2, 2, 0, 4);

    // timeout on second byte of a locked packet releases the lock
    n_err = 0;
    drop_idx = start_no + 1;
    rq[1].push_back({1'b0, 8'hB0});
    rq[1].push_back({1'b0, 8'hB1});
    rq[1].push_back({1'b1, 8'hB2});
    rq[3].push_back({1'b1, 8'hC0});
    drain(400);
    chk_order("timeout_order", 1, 1, 3, 1, 4);
    chk("timeout_count", n_err, 1);

    // busy gate: external busy blocks acceptance
    force_busy = 1'b1;
    rq[0].push_back({1'b1, 8'h3C});
    repeat (5) cyc();
    chk("gate_held", rq[0].size(), 1);
    force_busy = 1'b0;
    drain(200);
    chk_order("gate_order", 0, 0, 0, 0, 1);

    // reset while a locked packet's byte is in flight
    rq[2].push_back({1'b0, 8'h20});
    rq[2].push_back({1'b0, 8'h21});
    rq[2].push_back({1'b1, 8'h22});
    n = 0;
    while (!(m_locked && pend && got_busy && tx_busy) && n < 200) begin
      cyc();
      n++;
    end
    chk("reach_wait_done", n < 200, 1);
    do_reset();
    rq[0].push_back({1'b1, 8'h40});
    rq[1].push_back({1'b1, 8'h41});
    drain(200);
    chk_order("post_rst_order", 1, 0, 0, 0, 2);

    // random traffic
    frame_min = 1;
    frame_max = 4;
    rnd_drop  = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NR; i++)
        if (rq[i].size() == 0 && $urandom_range(7) == 0)
          push_pkt(i, $urandom_range(3, 1));
      cyc();
    end
    rnd_drop = 1'b0;
    drain(3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
